mtx_phase_gen: RTL and testbench

Multi-channel, runtime-configurable stepped-chirp phase generator for the main ANC transmit path. Produces time-interleaved phase words for NCH channels on an AXI-Stream master feeding the downstream sin/cos DDS LUT. Each symbol is a linear phase ramp whose increment grows and whose start phase rotates from symbol to symbol. Frame and sync markers, per-channel phase offsets and frame-boundary configuration reload are additions over the single-channel generator.

---
 rtl/mtx_phase_gen.sv | 200 ++++++++++++++++++++
 tb/tb_mtx_phase_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_phase_gen.sv
// Multi-channel stepped-chirp phase generator: time-interleaved phase words on an
// AXI-Stream master, with frame/sync markers, per-channel offsets and frame-boundary config reload.
module mtx_phase_gen #(
  parameter int unsigned PHASE_WIDTH  = 24,
  parameter int unsigned NSIG_WIDTH   = 16,
  parameter int unsigned NSYMB_WIDTH  = 16,
  parameter int unsigned NCH          = 4,
  parameter int unsigned CH_WIDTH     = 2,
  parameter int unsigned TX_SYNC_BITS = 2,
  parameter logic [NSIG_WIDTH-1:0]  DEF_NSIG      = NSIG_WIDTH'(5120),
  parameter logic [NSYMB_WIDTH-1:0] DEF_NSYMB     = NSYMB_WIDTH'(256),
  parameter logic [PHASE_WIDTH-1:0] DEF_START_PH  = PHASE_WIDTH'(24'h800000),
  parameter logic [PHASE_WIDTH-1:0] DEF_START_INC = PHASE_WIDTH'(8192),
  parameter logic [PHASE_WIDTH-1:0] DEF_DPH_INC   = PHASE_WIDTH'(16384),
  parameter logic [PHASE_WIDTH-1:0] DEF_NPH_SHIFT = PHASE_WIDTH'(0)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       srst,
  input  logic                       en,
  input  logic                       cfg_load,
  input  logic [NSIG_WIDTH-1:0]      cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0]     cfg_nsymb,
  input  logic [PHASE_WIDTH-1:0]     cfg_start_ph,
  input  logic [PHASE_WIDTH-1:0]     cfg_start_inc,
  input  logic [PHASE_WIDTH-1:0]     cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0]     cfg_nph_shift,
  input  logic [NCH*PHASE_WIDTH-1:0] cfg_ch_off,
  output logic [PHASE_WIDTH-1:0]     out_tdata,
  output logic [CH_WIDTH-1:0]        out_tchan,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       out_tlast,
  output logic                       out_tuser,
  output logic                       sync_ready,
  output logic [NSYMB_WIDTH-1:0]     symb_idx,
  output logic [NSIG_WIDTH-1:0]      samp_idx
);

  typedef struct packed {
    logic [NSIG_WIDTH-1:0]      nsig;
    logic [NSYMB_WIDTH-1:0]     nsymb;
    logic [PHASE_WIDTH-1:0]     start_ph;
    logic [PHASE_WIDTH-1:0]     start_inc;
    logic [PHASE_WIDTH-1:0]     dph_inc;
    logic [PHASE_WIDTH-1:0]     nph_shift;
    logic [NCH*PHASE_WIDTH-1:0] ch_off;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{
    nsig:      DEF_NSIG,
    nsymb:     DEF_NSYMB,
    start_ph:  DEF_START_PH,
    start_inc: DEF_START_INC,
    dph_inc:   DEF_DPH_INC,
    nph_shift: DEF_NPH_SHIFT,
    ch_off:    '0
  };

  localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(NCH - 1);

  cfg_t cfg_in, shadow_q, act_q, eff;

  // Position and ramp state of the next beat to be loaded.
  logic [NSYMB_WIDTH-1:0]  k_q, k_d, nsymb_last;
  logic [NSIG_WIDTH-1:0]   n_q, n_d, nsig_last;
  logic [CH_WIDTH-1:0]     c_q, c_d;
  logic [PHASE_WIDTH-1:0]  base_q, base_d, inc_q, inc_d, sym_q, sym_d;
  logic [PHASE_WIDTH-1:0]  cur_base, cur_inc, cur_sym, beat_data;
  logic                    frame_start, beat_last, load_beat;
  logic [TX_SYNC_BITS-1:0] sync_cnt_q;

  logic [PHASE_WIDTH-1:0] tdata_q;
  logic [CH_WIDTH-1:0]    tchan_q;
  logic                   tvalid_q, tlast_q, tuser_q, sync_q;
  logic [NSYMB_WIDTH-1:0] symb_q;
  logic [NSIG_WIDTH-1:0]  samp_q;

  assign cfg_in = '{
    nsig:      cfg_nsig,
    nsymb:     cfg_nsymb,
    start_ph:  cfg_start_ph,
    start_inc: cfg_start_inc,
    dph_inc:   cfg_dph_inc,
    nph_shift: cfg_nph_shift,
    ch_off:    cfg_ch_off
  };

  assign load_beat = en & (~tvalid_q | out_tready);

  // The first beat of a frame is built from the shadow set, so a frame never mixes configs.
  always_comb begin
    // NOTE: every signal driven here is assigned unconditionally first, so no latch is inferred.
    frame_start = (k_q == '0) && (n_q == '0) && (c_q == '0);
    eff         = frame_start ? shadow_q : act_q;
    nsig_last   = (eff.nsig  == '0) ? '0 : eff.nsig  - NSIG_WIDTH'(1);
    nsymb_last  = (eff.nsymb == '0) ? '0 : eff.nsymb - NSYMB_WIDTH'(1);
    cur_base    = frame_start ? eff.start_ph  : base_q;
    cur_inc     = frame_start ? eff.start_inc : inc_q;
    cur_sym     = frame_start ? eff.start_ph  : sym_q;
    beat_data   = cur_base + eff.ch_off[c_q*PHASE_WIDTH +: PHASE_WIDTH];
    beat_last   = (n_q == nsig_last) && (c_q == CH_LAST);

    k_d    = k_q;
    n_d    = n_q;
    c_d    = c_q;
    base_d = cur_base;
    inc_d  = cur_inc;
    sym_d  = cur_sym;
    if (c_q != CH_LAST) begin
      c_d = c_q + CH_WIDTH'(1);
    end else begin
      c_d = '0;
      if (n_q != nsig_last) begin
        n_d    = n_q + NSIG_WIDTH'(1);
        base_d = cur_base + cur_inc;
      end else begin
        n_d    = '0;
        sym_d  = cur_sym - eff.nph_shift;
        inc_d  = cur_inc + eff.dph_inc;
        base_d = sym_d;
        k_d    = (k_q == nsymb_last) ? '0 : k_q + NSYMB_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      shadow_q   <= CFG_DEF;
      act_q      <= CFG_DEF;
      k_q        <= '0;
      n_q        <= '0;
      c_q        <= '0;
      base_q     <= '0;
      inc_q      <= '0;
      sym_q      <= '0;
      sync_cnt_q <= '1;
      tdata_q    <= '0;
      tchan_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      sync_q     <= 1'b1;
      symb_q     <= '0;
      samp_q     <= '0;
    end else begin
      if (cfg_load) shadow_q <= cfg_in;
      if (srst) begin
        act_q      <= shadow_q;
        k_q        <= '0;
        n_q        <= '0;
        c_q        <= '0;
        base_q     <= '0;
        inc_q      <= '0;
        sym_q      <= '0;
        sync_cnt_q <= '1;
        tdata_q    <= '0;
        tchan_q    <= '0;
        tvalid_q   <= 1'b0;
        tlast_q    <= 1'b0;
        tuser_q    <= 1'b0;
        sync_q     <= 1'b1;
        symb_q     <= '0;
        samp_q     <= '0;
      end else if (load_beat) begin
        if (frame_start) begin
          act_q      <= shadow_q;
          sync_cnt_q <= sync_cnt_q + TX_SYNC_BITS'(1);
          sync_q     <= &sync_cnt_q;
        end
        k_q      <= k_d;
        n_q      <= n_d;
        c_q      <= c_d;
        base_q   <= base_d;
        inc_q    <= inc_d;
        sym_q    <= sym_d;
        tdata_q  <= beat_data;
        tchan_q  <= c_q;
        tvalid_q <= 1'b1;
        tlast_q  <= beat_last;
        tuser_q  <= frame_start;
        symb_q   <= k_q;
        samp_q   <= n_q;
      end else if (tvalid_q && out_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tchan  = tchan_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign out_tuser  = tuser_q;
  assign sync_ready = sync_q;
  assign symb_idx   = symb_q;
  assign samp_idx   = samp_q;

endmodule

// File: tb/tb_mtx_phase_gen.sv
// Bench for mtx_phase_gen (NCH=2): closed-form phase model checked on every accepted beat,
// handshake and stall-stability checks every cycle, plus hand-computed literal expectations.
module tb_mtx_phase_gen;

  typedef struct packed {
    logic [15:0] nsig;
    logic [15:0] nsymb;
    logic [23:0] start_ph;
    logic [23:0] start_inc;
    logic [23:0] dph;
    logic [23:0] nph;
    logic [47:0] off;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{nsig: 16'd5120, nsymb: 16'd256, start_ph: 24'h800000,
                               start_inc: 24'd8192, dph: 24'd16384, nph: 24'd0, off: 48'd0};

  logic        clk = 1'b0;
  logic        reset, srst, en, cfg_load, out_tready;
  cfg_t        drv;
  logic [23:0] out_tdata;
  logic        out_tchan, out_tvalid, out_tlast, out_tuser, sync_ready;
  logic [15:0] symb_idx, samp_idx;

  mtx_phase_gen #(.NCH(2), .CH_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .srst(srst), .en(en), .cfg_load(cfg_load),
    .cfg_nsig(drv.nsig), .cfg_nsymb(drv.nsymb), .cfg_start_ph(drv.start_ph),
    .cfg_start_inc(drv.start_inc), .cfg_dph_inc(drv.dph), .cfg_nph_shift(drv.nph),
    .cfg_ch_off(drv.off), .out_tdata(out_tdata), .out_tchan(out_tchan),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tuser(out_tuser), .sync_ready(sync_ready), .symb_idx(symb_idx), .samp_idx(samp_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Closed-form phase of symbol k, sample n, channel ch.
  function automatic logic [23:0] model_phase(input cfg_t c, input int k, input int n, input int ch);
    longint p;
    p = longint'(c.start_ph) - longint'(k) * longint'(c.nph)
      + longint'(n) * (longint'(c.start_inc) + longint'(k) * longint'(c.dph))
      + longint'((ch == 0) ? c.off[23:0] : c.off[47:24]);
    return p[23:0];
  endfunction

  // Reference state: shadow/active config, position of the next expected beat, frame count.
  cfg_t        sh, act;
  int          mk, mn, mc, mframe;
  logic        exp_valid, prev_stall;
  logic [59:0] held;
  logic [23:0] rec_data[$];
  bit          rec_last[$], rec_user[$], rec_sync[$];

  always @(negedge clk) begin
    logic [59:0] cur;
    int ns, nk;
    cur = {out_tdata, out_tchan, out_tlast, out_tuser, sync_ready, symb_idx, samp_idx};
    if (reset) begin
      sh = DEF_CFG; act = DEF_CFG;
      mk = 0; mn = 0; mc = 0; mframe = -1;
      exp_valid = 1'b0; prev_stall = 1'b0;
    end else begin
      check("tvalid", out_tvalid, exp_valid);
      if (prev_stall) check("stall_hold", cur, held);
      if (srst) begin
        act = sh;
        mk = 0; mn = 0; mc = 0; mframe = -1;
        exp_valid = 1'b0; prev_stall = 1'b0;
        if (cfg_load) sh = drv;
      end else begin
        if (out_tvalid && out_tready) begin
          if (mk == 0 && mn == 0 && mc == 0) begin
            act = sh;
            mframe++;
          end
          ns = (act.nsig == 0) ? 1 : int'(act.nsig);
          nk = (act.nsymb == 0) ? 1 : int'(act.nsymb);
          check("beat_data", out_tdata, model_phase(act, mk, mn, mc));
          check("beat_chan", out_tchan, mc);
          check("beat_last", out_tlast, (mn == ns - 1) && (mc == 1));
          check("beat_user", out_tuser, (mk == 0) && (mn == 0) && (mc == 0));
          check("beat_sync", sync_ready, (mframe % 4) == 0);
          check("beat_symb", symb_idx, mk);
          check("beat_samp", samp_idx, mn);
          rec_data.push_back(out_tdata);
          rec_last.push_back(out_tlast);
          rec_user.push_back(out_tuser);
          rec_sync.push_back(sync_ready);
          mc++;
          if (mc == 2) begin
            mc = 0; mn++;
            if (mn == ns) begin
              mn = 0; mk++;
              if (mk == nk) mk = 0;
            end
          end
        end
        if (cfg_load) sh = drv;
        prev_stall = out_tvalid && !out_tready;
        held = cur;
        if (en && (!out_tvalid || out_tready)) exp_valid = 1'b1;
        else if (out_tvalid && out_tready) exp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int ncyc, input int rdy_pct, input int en_pct);
    for (int i = 0; i < ncyc; i++) begin
      out_tready = ($urandom_range(0, 99) < rdy_pct);
      en         = ($urandom_range(0, 99) < en_pct);
      tick();
    end
  endtask

  task automatic load_cfg(input cfg_t c);
    drv = c;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_srst();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic drain();
    en = 1'b0;
    out_tready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic clear_rec();
    rec_data.delete(); rec_last.delete(); rec_user.delete(); rec_sync.delete();
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.nsig      = 16'($urandom_range(0, 5));
    c.nsymb     = 16'($urandom_range(0, 3));
    c.start_ph  = 24'($urandom);
    c.start_inc = 24'($urandom);
    c.dph       = 24'($urandom);
    c.nph       = 24'($urandom);
    c.off       = {24'($urandom), 24'($urandom)};
    return c;
  endfunction

  // Random traffic; config reloads only happen while the output register is empty and idle.
  task automatic run_rand(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 24) == 0 && !out_tvalid) begin
        en = 1'b0;
        drv = rand_cfg();
        cfg_load = 1'b1;
      end else begin
        cfg_load   = 1'b0;
        out_tready = ($urandom_range(0, 99) < 70);
        en         = ($urandom_range(0, 99) < 80);
      end
      tick();
    end
    cfg_load = 1'b0;
  endtask

  cfg_t cfg_a, cfg_wrap, cfg_sync, cfg_b, cfg_b2, cfg_c, cfg_zero;
  logic [8:0] sync_pat;

  initial begin
    cfg_a    = '{nsig: 16'd4, nsymb: 16'd3, start_ph: 24'h800000, start_inc: 24'h002000,
                 dph: 24'h004000, nph: 24'h001000, off: {24'h400000, 24'h000000}};
    cfg_wrap = '{nsig: 16'd3, nsymb: 16'd1, start_ph: 24'hFFF000, start_inc: 24'h002000,
                 dph: 24'h0, nph: 24'h0, off: 48'h0};
    cfg_sync = '{nsig: 16'd1, nsymb: 16'd1, start_ph: 24'h000100, start_inc: 24'h000010,
                 dph: 24'h0, nph: 24'h0, off: 48'h0};
    cfg_b    = '{nsig: 16'd4, nsymb: 16'd2, start_ph: 24'h800000, start_inc: 24'h002000,
                 dph: 24'h004000, nph: 24'h001000, off: {24'h400000, 24'h000000}};
    cfg_b2   = cfg_b;
    cfg_b2.nsig = 16'd2;
    cfg_c    = '{nsig: 16'd2, nsymb: 16'd1, start_ph: 24'h123456, start_inc: 24'h000010,
                 dph: 24'h0, nph: 24'h0, off: {24'h000000, 24'h000111}};
    cfg_zero = '{nsig: 16'd0, nsymb: 16'd0, start_ph: 24'h000010, start_inc: 24'h000005,
                 dph: 24'h000007, nph: 24'h000003, off: {24'h000020, 24'h000000}};
    sync_pat = 9'b1_0001_0001;

    reset = 1'b0; srst = 1'b0; en = 1'b0; cfg_load = 1'b0; out_tready = 1'b0;
    drv = DEF_CFG;
    #1 reset = 1'b1;
    #2;
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_tlast", out_tlast, 0);
    check("rst_tuser", out_tuser, 0);
    check("rst_tchan", out_tchan, 0);
    check("rst_symb", symb_idx, 0);
    check("rst_samp", samp_idx, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    check("model_pin_a", model_phase(cfg_a, 1, 3, 0), 24'h811000);
    check("model_pin_b", model_phase(cfg_a, 0, 3, 1), 24'hC06000);
    check("model_pin_c", model_phase(cfg_wrap, 0, 1, 0), 24'h001000);

    // Ramp with tready=1.
    load_cfg(cfg_a);
    do_srst();
    clear_rec();
    run(30, 100, 100);
    drain();
    check("ramp_c0_n0", rec_data[0], 24'h800000);
    check("ramp_c0_n1", rec_data[2], 24'h802000);
    check("ramp_c0_n2", rec_data[4], 24'h804000);
    check("ramp_c0_n3", rec_data[6], 24'h806000);
    check("ramp_c1_n0", rec_data[1], 24'hC00000);
    check("ramp_c1_n1", rec_data[3], 24'hC02000);
    check("ramp_c1_n2", rec_data[5], 24'hC04000);
    check("ramp_c1_n3", rec_data[7], 24'hC06000);
    check("ramp_s1_n0", rec_data[8], 24'h7FF000);
    check("ramp_s1_n1", rec_data[10], 24'h805000);
    check("ramp_s1_n2", rec_data[12], 24'h80B000);
    check("ramp_s1_n3", rec_data[14], 24'h811000);
    for (int i = 0; i < 26; i++) begin
      check("ramp_tlast", rec_last[i], (i == 7 || i == 15 || i == 23));
      check("ramp_tuser", rec_user[i], (i == 0 || i == 24));
    end

    // Backpressure: same sequence under random tready.
    do_srst();
    clear_rec();
    run(90, 50, 100);
    drain();
    check("bp_len", rec_data.size() >= 24, 1);
    for (int i = 0; i < 24; i++)
      check("bp_seq", rec_data[i], model_phase(cfg_a, i / 8, (i % 8) / 2, i % 2));

    // Enable toggling: no gaps, no repeats.
    do_srst();
    clear_rec();
    run(120, 80, 60);
    drain();
    check("en_len", rec_data.size() >= 30, 1);
    for (int i = 0; i < 30; i++)
      check("en_seq", rec_data[i], model_phase(cfg_a, (i % 24) / 8, (i % 8) / 2, i % 2));

    // Phase wrap.
    load_cfg(cfg_wrap);
    do_srst();
    clear_rec();
    run(10, 100, 100);
    drain();
    check("wrap_0", rec_data[0], 24'hFFF000);
    check("wrap_1", rec_data[2], 24'h001000);
    check("wrap_2", rec_data[4], 24'h003000);
    check("wrap_3", rec_data[6], 24'hFFF000);

    // Sync frames: 2-beat frames, sync in frames 0, 4, 8.
    load_cfg(cfg_sync);
    do_srst();
    clear_rec();
    run(24, 100, 100);
    drain();
    for (int f = 0; f < 9; f++) begin
      check("sync_frame", rec_sync[2*f], sync_pat[f]);
      check("sync_user", rec_user[2*f], 1);
    end

    // Mid-frame reload: 16-beat frame completes, then 8-beat frames.
    load_cfg(cfg_b);
    do_srst();
    clear_rec();
    run(6, 100, 100);
    load_cfg(cfg_b2);
    run(30, 100, 100);
    for (int i = 0; i < 33; i++)
      check("reload_tuser", rec_user[i], (i == 0 || i == 16 || i == 24 || i == 32));

    // srst mid-stream restarts with the freshly loaded shadow.
    run(5, 100, 100);
    load_cfg(cfg_c);
    do_srst();
    clear_rec();
    run(4, 100, 100);
    drain();
    check("srst_tuser", rec_user[0], 1);
    check("srst_d0", rec_data[0], 24'h123567);
    check("srst_d1", rec_data[1], 24'h123456);
    check("srst_d2", rec_data[2], 24'h123577);

    // nsig = nsymb = 0 behave as 1.
    load_cfg(cfg_zero);
    do_srst();
    clear_rec();
    run(8, 100, 100);
    drain();
    check("zero_last0", rec_last[0], 0);
    check("zero_last1", rec_last[1], 1);
    check("zero_user2", rec_user[2], 1);
    check("zero_d3", rec_data[3], 24'h000030);

    // Random configs and traffic.
    for (int r = 0; r < 6; r++) begin
      drain();
      load_cfg(rand_cfg());
      do_srst();
      run_rand(150);
    end

    // Asynchronous reset mid-stream.
    drain();
    load_cfg(cfg_a);
    do_srst();
    run(13, 100, 100);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tvalid", out_tvalid, 0);
    check("async_rst_tdata", out_tdata, 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    load_cfg(cfg_a);
    do_srst();
    clear_rec();
    run(6, 100, 100);
    drain();
    check("post_rst_d0", rec_data[0], 24'h800000);
    check("post_rst_d1", rec_data[1], 24'hC00000);
    check("post_rst_user", rec_user[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
